ccd_line_emulator: RTL and testbench

- Synthesizable responder for the TCD1209D driver/AD9945 chain: consumes the driver's sh and f1 timing outputs and returns one D_WIDTH-bit pixel sample per f1 rising edge, emulating a CCD plus ADC.
- Lets bring-up and regression benches exercise TCD1209D/ccd2axis/rows_resize with deterministic, checkable line content and no sensor attached.
- Sits between the driver's sh/f1 outputs and its DATA_IN input, in the same clock domain.

---
 rtl/ccd_emu_pkg.sv | 34 +++
 rtl/ccd_pattern_gen.sv | 37 +++
 rtl/ccd_line_emulator.sv | 184 ++++++++++++++++++
 tb/tb_ccd_line_emulator.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccd_emu_pkg.sv
// rtl/ccd_emu_pkg.sv - shared types and sizing helpers for the CCD line emulator
// Purpose: FSM state encoding, sample region type, pattern codes and the
//          line-length / pixel-counter-width helpers used by the emulator.
// Ports:   none (package).
package ccd_emu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEAD   = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_TAIL   = 3'd3,
        ST_POST   = 3'd4
    } state_e;

    typedef enum logic {
        REG_DARK   = 1'b0,
        REG_ACTIVE = 1'b1
    } region_e;

    localparam logic [1:0] PAT_RAMP  = 2'd0;
    localparam logic [1:0] PAT_CONST = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_LRAMP = 2'd3;

    function automatic int total_pix(input int lead, input int eff, input int tail);
        return lead + eff + tail;
    endfunction

    // Counter must hold indices 0..total-1; never narrower than one bit.
    function automatic int pix_cnt_w(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/ccd_pattern_gen.sv
// rtl/ccd_pattern_gen.sv - combinational pixel value generator
// Purpose: produces the next sample for the current pixel from its region,
//          the latched pattern code and the line/pixel indices.
// Ports:   region    - dark (dummy) or active pixel
//          pattern   - latched pattern code
//          const_val - latched constant for the constant pattern
//          act_idx   - active pixel index, already truncated to D_WIDTH
//          line_lsb  - completed-line count truncated to D_WIDTH
//          sample    - value to present on data_out
module ccd_pattern_gen
    import ccd_emu_pkg::*;
#(
    parameter int                   D_WIDTH    = 12,
    parameter logic [D_WIDTH-1:0]   DARK_LEVEL = D_WIDTH'('h040)
) (
    input  region_e              region,
    input  logic [1:0]           pattern,
    input  logic [D_WIDTH-1:0]   const_val,
    input  logic [D_WIDTH-1:0]   act_idx,
    input  logic [D_WIDTH-1:0]   line_lsb,
    output logic [D_WIDTH-1:0]   sample
);

    always_comb begin
        sample = DARK_LEVEL;
        if (region == REG_ACTIVE) begin
            case (pattern)
                PAT_RAMP:  sample = act_idx;
                PAT_CONST: sample = const_val;
                // Checker alternates per pixel and inverts on every other line.
                PAT_CHECK: sample = (act_idx[0] ^ line_lsb[0]) ? '1 : '0;
                default:   sample = act_idx + line_lsb;
            endcase
        end
    end

endmodule

// File: rtl/ccd_line_emulator.sv
// rtl/ccd_line_emulator.sv - CCD + ADC line responder for the TCD1209D driver
// Purpose: watches the driver's sh/f1 outputs and answers every f1 rising edge
//          with one deterministic pixel sample, one clock later.
// Ports:   clk, reset (async, active-high)
//          sh, f1              - driver timing inputs, synchronous to clk
//          pattern, const_val  - content selection, latched at sh rise
//          data_out/data_valid - sample and its one-cycle strobe
//          line_start          - pulse on every accepted sh rise
//          line_done           - pulse with the last tail pixel
//          line_cnt            - completed lines, wraps at 2^16
//          err_short           - sh rose while a line was still in progress
//          err_overrun         - f1 rose after line_done and before next sh
module ccd_line_emulator
    import ccd_emu_pkg::*;
#(
    parameter int                   D_WIDTH    = 12,
    parameter int                   LEAD_PIX   = 32,
    parameter int                   EFF_PIX    = 2048,
    parameter int                   TAIL_PIX   = 22,
    parameter logic [D_WIDTH-1:0]   DARK_LEVEL = D_WIDTH'('h040)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sh,
    input  logic                 f1,
    input  logic [1:0]           pattern,
    input  logic [D_WIDTH-1:0]   const_val,
    output logic [D_WIDTH-1:0]   data_out,
    output logic                 data_valid,
    output logic                 line_start,
    output logic                 line_done,
    output logic [15:0]          line_cnt,
    output logic                 err_short,
    output logic                 err_overrun
);

    localparam int              TOTAL_PIX = total_pix(LEAD_PIX, EFF_PIX, TAIL_PIX);
    localparam int              PCW       = pix_cnt_w(TOTAL_PIX);
    localparam logic [PCW-1:0]  LAST_K    = PCW'(TOTAL_PIX - 1);

    state_e               state_q, state_d;
    logic [PCW-1:0]       pix_cnt_q, pix_cnt_d;
    logic [1:0]           pat_q, pat_d;
    logic [D_WIDTH-1:0]   const_q, const_d;
    logic [15:0]          line_cnt_q, line_cnt_d;
    logic [D_WIDTH-1:0]   data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 line_start_q, line_start_d;
    logic                 line_done_q, line_done_d;
    logic                 err_short_q, err_short_d;
    logic                 err_overrun_q, err_overrun_d;
    logic                 sh_dly_q, sh_dly_d;
    logic                 f1_dly_q, f1_dly_d;

    logic                 sh_rise;
    logic                 f1_rise;
    logic                 in_line;
    logic [PCW-1:0]       pix_inc;
    logic [D_WIDTH-1:0]   act_idx;
    logic [D_WIDTH-1:0]   line_lsb;
    logic [D_WIDTH-1:0]   gen_sample;
    region_e              gen_region;

    // Region owning pixel k. Zero-length lead/tail regions fall through,
    // so the first rise lands directly in the following region's rule.
    function automatic state_e state_for(input logic [PCW-1:0] k);
        if (int'(k) < LEAD_PIX) begin
            return ST_LEAD;
        end else if (int'(k) < LEAD_PIX + EFF_PIX) begin
            return ST_ACTIVE;
        end else begin
            return ST_TAIL;
        end
    endfunction

    assign sh_rise    = sh & ~sh_dly_q;
    assign f1_rise    = f1 & ~f1_dly_q;
    assign in_line    = (state_q == ST_LEAD) || (state_q == ST_ACTIVE) || (state_q == ST_TAIL);
    assign pix_inc    = pix_cnt_q + PCW'(1);
    assign act_idx    = D_WIDTH'(pix_cnt_q) - D_WIDTH'(LEAD_PIX);
    assign line_lsb   = D_WIDTH'(line_cnt_q);
    assign gen_region = (state_q == ST_ACTIVE) ? REG_ACTIVE : REG_DARK;

    ccd_pattern_gen #(
        .D_WIDTH    (D_WIDTH),
        .DARK_LEVEL (DARK_LEVEL)
    ) u_pattern_gen (
        .region    (gen_region),
        .pattern   (pat_q),
        .const_val (const_q),
        .act_idx   (act_idx),
        .line_lsb  (line_lsb),
        .sample    (gen_sample)
    );

    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        pat_d         = pat_q;
        const_d       = const_q;
        line_cnt_d    = line_cnt_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        line_start_d  = 1'b0;
        line_done_d   = 1'b0;
        err_short_d   = 1'b0;
        err_overrun_d = 1'b0;
        sh_dly_d      = sh;
        f1_dly_d      = f1;

        // sh has priority: a coincident f1 rise is swallowed.
        if (sh_rise) begin
            pix_cnt_d    = '0;
            line_start_d = 1'b1;
            pat_d        = pattern;
            const_d      = const_val;
            err_short_d  = in_line;
            state_d      = state_for('0);
        end else if (f1_rise) begin
            case (state_q)
                ST_LEAD, ST_ACTIVE, ST_TAIL: begin
                    data_valid_d = 1'b1;
                    data_out_d   = gen_sample;
                    if (pix_cnt_q == LAST_K) begin
                        line_done_d = 1'b1;
                        line_cnt_d  = line_cnt_q + 16'd1;
                        state_d     = ST_POST;
                    end else begin
                        pix_cnt_d = pix_inc;
                        state_d   = state_for(pix_inc);
                    end
                end
                ST_POST: begin
                    data_valid_d  = 1'b1;
                    data_out_d    = DARK_LEVEL;
                    err_overrun_d = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pix_cnt_q     <= '0;
            pat_q         <= '0;
            const_q       <= '0;
            line_cnt_q    <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            line_start_q  <= 1'b0;
            line_done_q   <= 1'b0;
            err_short_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            sh_dly_q      <= 1'b0;
            f1_dly_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            pat_q         <= pat_d;
            const_q       <= const_d;
            line_cnt_q    <= line_cnt_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            line_start_q  <= line_start_d;
            line_done_q   <= line_done_d;
            err_short_q   <= err_short_d;
            err_overrun_q <= err_overrun_d;
            sh_dly_q      <= sh_dly_d;
            f1_dly_q      <= f1_dly_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign line_start  = line_start_q;
    assign line_done   = line_done_q;
    assign line_cnt    = line_cnt_q;
    assign err_short   = err_short_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_ccd_line_emulator.sv
// tb/tb_ccd_line_emulator.sv - scoreboard bench for ccd_line_emulator
module tb_ccd_line_emulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        sh;
    logic        f1;
    logic [1:0]  pattern;
    logic [11:0] const_val;
    logic [11:0] data_out;
    logic        data_valid;
    logic        line_start;
    logic        line_done;
    logic [15:0] line_cnt;
    logic        err_short;
    logic        err_overrun;

    ccd_line_emulator dut (
        .clk         (clk),
        .reset       (reset),
        .sh          (sh),
        .f1          (f1),
        .pattern     (pattern),
        .const_val   (const_val),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .line_start  (line_start),
        .line_done   (line_done),
        .line_cnt    (line_cnt),
        .err_short   (err_short),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] data;
        logic        done;
        logic        ovr;
        logic [15:0] lcnt;
    } exp_t;

    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    int cnt_valid = 0;
    int cnt_line_start = 0;
    int cnt_err_short = 0;
    int cnt_line_done = 0;
    int cnt_err_ovr = 0;

    // Reference line model
    int          m_state = 0;   // 0 idle, 1 in line, 2 after line_done
    int          m_k = 0;
    logic [1:0]  m_pat = 2'd0;
    logic [11:0] m_const = 12'd0;
    logic [15:0] m_lc = 16'd0;
    int          m_exp_short = 0;
    int          m_exp_start = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [11:0] model_pix(input int k, input logic [1:0] pat,
                                              input logic [11:0] cv, input logic [15:0] lc);
        logic [11:0] a;
        logic [11:0] lcl;
        if (k < 32 || k >= 2080) return 12'h040;
        a   = 12'(k - 32);
        lcl = lc[11:0];
        case (pat)
            2'd0:    return a;
            2'd1:    return cv;
            2'd2:    return (a[0] ^ lcl[0]) ? 12'hFFF : 12'h000;
            default: return a + lcl;
        endcase
    endfunction

    task automatic model_f1();
        exp_t e;
        if (m_state == 1) begin
            e.data = model_pix(m_k, m_pat, m_const, m_lc);
            e.done = (m_k == 2101);
            e.ovr  = 1'b0;
            e.lcnt = (m_k == 2101) ? m_lc + 16'd1 : m_lc;
            sbq.push_back(e);
            if (m_k == 2101) begin
                m_lc    = m_lc + 16'd1;
                m_state = 2;
            end else begin
                m_k++;
            end
        end else if (m_state == 2) begin
            e.data = 12'h040;
            e.done = 1'b0;
            e.ovr  = 1'b1;
            e.lcnt = m_lc;
            sbq.push_back(e);
        end
    endtask

    task automatic model_sh();
        if (m_state == 1) m_exp_short++;
        m_exp_start++;
        m_state = 1;
        m_k     = 0;
        m_pat   = pattern;
        m_const = const_val;
    endtask

    task automatic f1_pulse(input int hi, input int lo);
        f1 = 1'b1;
        model_f1();
        repeat (hi) @(negedge clk);
        f1 = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic sh_pulse();
        sh = 1'b1;
        model_sh();
        repeat (2) @(negedge clk);
        sh = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, sbq.size(), 0);
    endtask

    // Output monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (line_start)  cnt_line_start++;
            if (err_short)   cnt_err_short++;
            if (line_done)   cnt_line_done++;
            if (err_overrun) cnt_err_ovr++;
            if (data_valid) begin
                exp_t e;
                cnt_valid++;
                checks++;
                assert (sbq.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_valid: observed data %0h expected no strobe", data_out);
                end
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("pixel", {data_out, line_done, err_overrun, line_cnt}, e);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        reset     = 1'b1;
        sh        = 1'b0;
        f1        = 1'b0;
        pattern   = 2'd0;
        const_val = 12'd0;
        repeat (3) @(negedge clk);
        check("reset_outs", {data_out, data_valid, line_start, line_done, line_cnt, err_short, err_overrun}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_outs", {data_out, data_valid, line_start, line_done, line_cnt, err_short, err_overrun}, 0);

        // f1 in IDLE is ignored
        repeat (3) f1_pulse(1, 1);
        check("idle_no_valid", cnt_valid, 0);

        // Nominal pattern-0 line at f1 period 10, plus 3 overrun rises
        pattern = 2'd0;
        sh_pulse();
        check("line0_start", cnt_line_start, m_exp_start);
        repeat (2105) f1_pulse(5, 5);
        drain("line0_drain");
        check("line0_valid_cnt", cnt_valid, 2105);
        check("line0_done_cnt", cnt_line_done, 1);
        check("line0_ovr_cnt", cnt_err_ovr, 3);
        check("line0_lcnt", line_cnt, 1);

        // Checker line on line_cnt=1; sh after overrun is not short
        pattern = 2'd2;
        sh_pulse();
        check("post_sh_no_short", cnt_err_short, 0);
        repeat (2102) f1_pulse(1, 1);
        drain("line1_drain");
        check("line1_lcnt", line_cnt, 2);
        check("line1_done_cnt", cnt_line_done, 2);

        // Short line: restart after 100 pixels
        pattern   = 2'd1;
        const_val = 12'hABC;
        sh_pulse();
        repeat (100) f1_pulse(1, 1);
        drain("short_drain");
        pattern = 2'd0;
        sh_pulse();
        check("short_err", cnt_err_short, m_exp_short);
        check("short_start", cnt_line_start, m_exp_start);
        f1_pulse(1, 1);
        drain("short_next_drain");
        check("short_lcnt", line_cnt, m_lc);

        // Coincident sh and f1 rises inside ACTIVE
        repeat (40) f1_pulse(1, 1);
        drain("same_pre_drain");
        v0 = cnt_valid;
        sh = 1'b1;
        f1 = 1'b1;
        model_sh();
        repeat (2) @(negedge clk);
        sh = 1'b0;
        f1 = 1'b0;
        repeat (2) @(negedge clk);
        check("same_no_valid", cnt_valid, v0);
        check("same_err_short", cnt_err_short, m_exp_short);
        f1_pulse(1, 1);
        drain("same_next_drain");

        // Asynchronous reset in the middle of ACTIVE
        repeat (50) f1_pulse(1, 1);
        drain("rst_pre_drain");
        #3 reset = 1'b1;
        #1;
        check("async_rst_outs", {data_out, data_valid, line_start, line_done, line_cnt, err_short, err_overrun}, 0);
        m_state = 0;
        m_lc    = 16'd0;
        repeat (3) @(negedge clk);
        #4 reset = 1'b0;
        @(negedge clk);
        check("rst_lcnt", line_cnt, 0);
        v0 = cnt_valid;
        repeat (3) f1_pulse(1, 1);
        check("rst_no_valid", cnt_valid, v0);

        // Three line-offset ramp lines
        for (int l = 0; l < 3; l++) begin
            pattern = 2'd3;
            sh_pulse();
            repeat (2102) f1_pulse(1, 1);
            drain("lramp_drain");
        end
        check("lramp_lcnt", line_cnt, 3);
        check("final_err_short", cnt_err_short, m_exp_short);
        check("final_start", cnt_line_start, m_exp_start);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
